// File: rtl/kernel_cc_fifo_arb_rr.sv
// Round-robin arbiter draining NUM_REQ upstream FIFOs into one downstream FIFO through a one-entry output buffer.
// Optional macro KERNEL_CC_FIFO_ARB_TAG_EN prepends the source ID to out_din.
module kernel_cc_fifo_arb_rr #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            in_empty_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_dout,
    output logic [NUM_REQ-1:0]            in_read,
    input  logic                          out_full_n,
    output logic                          out_write,
`ifdef KERNEL_CC_FIFO_ARB_TAG_EN
    output logic [DATA_WIDTH+ID_WIDTH-1:0] out_din,
`else
    output logic [DATA_WIDTH-1:0]         out_din,
`endif
    input  logic                          quiesce,
    output logic                          idle,
    output logic [31:0]                   beat_cnt
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [31:0]           beat_cnt_q, beat_cnt_d;
`ifdef KERNEL_CC_FIFO_ARB_TAG_EN
    logic [ID_WIDTH-1:0]   id_q, id_d;
`endif

    logic                  xfer_out;
    logic                  grant_ok;
    logic                  gnt_vld;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic                  grant;

    assign xfer_out = valid_q & out_full_n;
    // in_read is combinational, so it must be gated by reset_n to stay low while reset is held
    assign grant_ok = reset_n & ~quiesce & (~valid_q | out_full_n);

    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_vld && in_empty_n[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = ID_WIDTH'(idx);
            end
        end
    end

    assign grant   = grant_ok & gnt_vld;
    assign in_read = grant ? (NUM_REQ'(1) << gnt_idx) : '0;

    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q + 32'(xfer_out);
`ifdef KERNEL_CC_FIFO_ARB_TAG_EN
        id_d       = id_q;
`endif
        if (xfer_out) valid_d = 1'b0;
        // a refill on the drain edge overrides the clear, so back-to-back words leave no bubble
        if (grant) begin
            valid_d  = 1'b1;
            data_d   = in_dout[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            rr_ptr_d = (gnt_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : gnt_idx + ID_WIDTH'(1);
`ifdef KERNEL_CC_FIFO_ARB_TAG_EN
            id_d     = gnt_idx;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
`ifdef KERNEL_CC_FIFO_ARB_TAG_EN
            id_q       <= '0;
`endif
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
`ifdef KERNEL_CC_FIFO_ARB_TAG_EN
            id_q       <= id_d;
`endif
        end
    end

    assign out_write = valid_q;
`ifdef KERNEL_CC_FIFO_ARB_TAG_EN
    assign out_din   = {id_q, data_q};
`else
    assign out_din   = data_q;
`endif
    assign idle      = quiesce & ~valid_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_kernel_cc_fifo_arb_rr.sv
// Scoreboard bench: upstream FIFOs modelled as queues, expected downstream words queued as stimulus is loaded.
module tb_kernel_cc_fifo_arb_rr;
`ifdef KERNEL_CC_FIFO_ARB_TAG_EN
    localparam int OUT_W = 34;
`else
    localparam int OUT_W = 32;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [3:0]       in_empty_n;
    logic [127:0]     in_dout;
    logic [3:0]       in_read;
    logic             out_full_n;
    logic             out_write;
    logic [OUT_W-1:0] out_din;
    logic             quiesce;
    logic             idle;
    logic [31:0]      beat_cnt;

    kernel_cc_fifo_arb_rr dut (
        .clk(clk), .reset_n(reset_n), .in_empty_n(in_empty_n), .in_dout(in_dout),
        .in_read(in_read), .out_full_n(out_full_n), .out_write(out_write), .out_din(out_din),
        .quiesce(quiesce), .idle(idle), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0]      srcq[4][$];
    logic [OUT_W-1:0] exp_q[$];
    int               errors = 0;
    int               checks = 0;
    int               wr_cnt = 0;
    int               rd_cnt = 0;
    logic [3:0]       last_rd;

    function automatic logic [OUT_W-1:0] exp_word(input int id, input logic [31:0] d);
        logic [1:0] idb;
        idb = id[1:0];
`ifdef KERNEL_CC_FIFO_ARB_TAG_EN
        return {idb, d};
`else
        idb = idb;
        return d;
`endif
    endfunction

    task automatic load(input int id, input logic [31:0] d, input bit expect_out);
        srcq[id].push_back(d);
        if (expect_out) exp_q.push_back(exp_word(id, d));
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            in_empty_n[i]       = srcq[i].size() > 0;
            in_dout[i*32 +: 32] = (srcq[i].size() > 0) ? srcq[i][0] : 32'h0;
        end
    endtask

    // One cycle: drive at negedge, observe the settled pre-edge values, then apply pops after the edge.
    task automatic step(input logic full, input logic q);
        logic [OUT_W-1:0] e;
        logic [3:0]       rd;
        @(negedge clk);
        out_full_n = full;
        quiesce    = q;
        drive();
        #1;
        checks++;
        if ((in_read & ~in_empty_n) !== 4'b0) begin
            errors++; $display("FAIL read_on_empty: in_read=%b in_empty_n=%b", in_read, in_empty_n);
        end
        checks++;
        if (!$onehot0(in_read)) begin
            errors++; $display("FAIL read_onehot: in_read=%b", in_read);
        end
        if (out_write && out_full_n) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL unexpected_write: out_din=%h with empty scoreboard", out_din);
            end else begin
                e = exp_q.pop_front();
                if (out_din !== e) begin
                    errors++; $display("FAIL write_data: got %h want %h", out_din, e);
                end
            end
        end
        rd      = in_read;
        last_rd = rd;
        @(posedge clk);
        for (int i = 0; i < 4; i++)
            if (rd[i] && srcq[i].size() > 0) begin
                void'(srcq[i].pop_front());
                rd_cnt++;
            end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL %s_drain: %0d words left, want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        reset_n    = 1'b0;
        in_empty_n = 4'hF;
        quiesce    = 1'b1;
        #1;
        checks++;
        if (out_write !== 1'b0 || out_din !== '0 || beat_cnt !== 32'd0 || in_read !== 4'b0) begin
            errors++;
            $display("FAIL reset_outputs: write=%b din=%h beat=%0d read=%b want 0", out_write, out_din, beat_cnt, in_read);
        end
        checks++;
        if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle_q1: got %b want 1", idle); end
        quiesce = 1'b0;
        #1;
        checks++;
        if (idle !== 1'b0) begin errors++; $display("FAIL reset_idle_q0: got %b want 0", idle); end
        in_empty_n = 4'h0;
        for (int i = 0; i < 4; i++) srcq[i].delete();
        exp_q.delete();
        wr_cnt = 0;
        rd_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_round_robin();
        test_reset();
        load(0, 32'hA000_0000, 1); load(1, 32'hB111_1111, 1); load(2, 32'hC222_2222, 1);
        load(3, 32'hD333_3333, 1); load(0, 32'hA000_0001, 1);
        // scoreboard order 0,1,2,3,0 is the order words were loaded
        exp_q.delete();
        exp_q.push_back(exp_word(0, 32'hA000_0000)); exp_q.push_back(exp_word(1, 32'hB111_1111));
        exp_q.push_back(exp_word(2, 32'hC222_2222)); exp_q.push_back(exp_word(3, 32'hD333_3333));
        exp_q.push_back(exp_word(0, 32'hA000_0001));
        for (int c = 0; c < 6; c++) step(1'b1, 1'b0);
        #1;
        checks++;
        if (wr_cnt != 5) begin errors++; $display("FAIL rr_throughput: got %0d writes in 5 cycles want 5", wr_cnt); end
        checks++;
        if (beat_cnt !== 32'd5) begin errors++; $display("FAIL rr_beat_cnt: got %0d want 5", beat_cnt); end
        check_drained("rr");
    endtask

    task automatic test_backpressure();
        test_reset();
        load(2, 32'h2222_0000, 1);
        load(2, 32'h2222_0001, 1);
        step(1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0);
            checks++;
            if (out_write !== 1'b1 || out_din !== exp_word(2, 32'h2222_0000) || last_rd !== 4'b0) begin
                errors++;
                $display("FAIL bp_hold: write=%b din=%h read=%b want 1 %h 0000", out_write, out_din, last_rd, exp_word(2, 32'h2222_0000));
            end
        end
        checks++;
        if (rd_cnt != 1) begin errors++; $display("FAIL bp_single_pop: got %0d pops want 1", rd_cnt); end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        checks++;
        if (wr_cnt != 2) begin errors++; $display("FAIL bp_writes: got %0d want 2", wr_cnt); end
        check_drained("bp");
    endtask

    task automatic test_rr_ptr();
        test_reset();
        load(2, 32'h0000_F002, 1);
        step(1'b1, 1'b0);
        load(3, 32'h0000_F003, 1);
        load(0, 32'h0000_F000, 1);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0);
        check_drained("rr_ptr");
    endtask

    task automatic test_quiesce();
        test_reset();
        load(1, 32'h0001_0001, 1);
        step(1'b0, 1'b0);
        load(0, 32'h0000_0F00, 1);
        step(1'b1, 1'b1);
        #1;
        checks++;
        if (last_rd !== 4'b0) begin errors++; $display("FAIL q_no_read: got %b want 0000", last_rd); end
        checks++;
        if (out_write !== 1'b0 || idle !== 1'b1) begin
            errors++; $display("FAIL q_idle: write=%b idle=%b want 0 1", out_write, idle);
        end
        step(1'b1, 1'b1);
        checks++;
        if (last_rd !== 4'b0 || srcq[0].size() != 1) begin
            errors++; $display("FAIL q_hold_grant: read=%b pending=%0d want 0000 1", last_rd, srcq[0].size());
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_drained("quiesce");
    endtask

    task automatic test_reset_mid();
        test_reset();
        load(1, 32'h1055_1055, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        #3;
        checks++;
        if (out_write !== 1'b1) begin errors++; $display("FAIL rm_pre: write=%b want 1", out_write); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_write !== 1'b0 || out_din !== '0 || beat_cnt !== 32'd0 || in_read !== 4'b0) begin
            errors++;
            $display("FAIL rm_async: write=%b din=%h beat=%0d read=%b want 0", out_write, out_din, beat_cnt, in_read);
        end
        load(3, 32'h3333_AAAA, 0);
        load(1, 32'h1111_AAAA, 0);
        exp_q.push_back(exp_word(1, 32'h1111_AAAA));
        exp_q.push_back(exp_word(3, 32'h3333_AAAA));
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 1'b0);
        checks++;
        if (last_rd !== 4'b0010) begin errors++; $display("FAIL rm_first_grant: got %b want 0010", last_rd); end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        #1;
        checks++;
        if (beat_cnt !== 32'd2) begin errors++; $display("FAIL rm_beat_cnt: got %0d want 2", beat_cnt); end
        check_drained("reset_mid");
    endtask

    task automatic test_tag();
        logic [OUT_W-1:0] want;
`ifdef KERNEL_CC_FIFO_ARB_TAG_EN
        want = {2'b01, 32'hDEAD_BEEF};
`else
        want = 32'hDEAD_BEEF;
`endif
        test_reset();
        load(1, 32'hDEAD_BEEF, 1);
        step(1'b0, 1'b0);
        #1;
        checks++;
        if (out_din !== want) begin errors++; $display("FAIL tag_din: got %h want %h", out_din, want); end
        step(1'b1, 1'b0);
        check_drained("tag");
    endtask

    initial begin
        reset_n    = 1'b0;
        quiesce    = 1'b0;
        out_full_n = 1'b0;
        in_empty_n = 4'h0;
        in_dout    = '0;
        last_rd    = 4'h0;
        test_round_robin();
        test_backpressure();
        test_rr_ptr();
        test_quiesce();
        test_reset_mid();
        test_tag();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
